// File: rtl/rs_alu_scheduler_pkg.sv
// Shared types and defaults for the ALU reservation station.
// Optional build macro: RS_OLDEST_FIRST_EN (age-matrix oldest-ready selection).
package rs_alu_scheduler_pkg;

    localparam int RS_SIZE_DEF = 16;
    localparam int ROB_W       = 4;
    localparam int OPC_W       = 6;

    // ALU opcode_id encodings shared with the decoder
    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 6'd0,
        OP_ADD = 6'd1,
        OP_SUB = 6'd2,
        OP_AND = 6'd3,
        OP_OR  = 6'd4,
        OP_XOR = 6'd5,
        OP_SLL = 6'd6,
        OP_SRL = 6'd7,
        OP_SLT = 6'd8
    } opcode_e;

    // One reservation-station slot
    typedef struct packed {
        logic             valid;
        logic [OPC_W-1:0] opcode;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      a;
        logic             qj_busy;
        logic [ROB_W-1:0] qj;
        logic             qk_busy;
        logic [ROB_W-1:0] qk;
        logic [ROB_W-1:0] rob_pos;
    } rs_entry_t;

    // Registered request presented to the ALU
    typedef struct packed {
        logic             instr_valid;
        logic [OPC_W-1:0] opcode;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [31:0]      a;
        logic [ROB_W-1:0] rob_pos;
    } alu_req_t;

    // One source operand: pending flag plus captured value
    typedef struct packed {
        logic        busy;
        logic [31:0] val;
    } opnd_t;

    // Capture a broadcast for a pending operand; CDB0 wins when both ports match
    function automatic opnd_t snoop(
        input logic             busy,
        input logic [31:0]      val,
        input logic [ROB_W-1:0] tag,
        input logic             c0_valid,
        input logic [ROB_W-1:0] c0_tag,
        input logic [31:0]      c0_val,
        input logic             c1_valid,
        input logic [ROB_W-1:0] c1_tag,
        input logic [31:0]      c1_val
    );
        opnd_t r;
        r.busy = busy;
        r.val  = val;
        if (busy) begin
            if (c0_valid && (c0_tag == tag)) begin
                r.busy = 1'b0;
                r.val  = c0_val;
            end else if (c1_valid && (c1_tag == tag)) begin
                r.busy = 1'b0;
                r.val  = c1_val;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_alu_scheduler_if.sv
// Issue, CDB and ALU-side bus of the ALU reservation station.
// Optional build macro: RS_OLDEST_FIRST_EN (no effect on this interface).
//
// Issue handshake: issue_valid is the request and !rs_full is the ready.
// A request is taken on a rising edge where issue_valid=1, rs_full=0,
// rdy=1 and clear=0. While rs_full is high the issue stage keeps
// issue_valid and its payload stable; nothing is consumed.
interface rs_alu_scheduler_if;
    import rs_alu_scheduler_pkg::*;

    logic             issue_valid;
    logic [OPC_W-1:0] issue_opcode;
    logic [31:0]      issue_vj;
    logic [31:0]      issue_vk;
    logic [31:0]      issue_A;
    logic             issue_qj_busy;
    logic             issue_qk_busy;
    logic [ROB_W-1:0] issue_qj;
    logic [ROB_W-1:0] issue_qk;
    logic [ROB_W-1:0] issue_rob_pos;
    logic             rs_full;

    logic             cdb0_valid;
    logic [ROB_W-1:0] cdb0_rob_pos;
    logic [31:0]      cdb0_val;
    logic             cdb1_valid;
    logic [ROB_W-1:0] cdb1_rob_pos;
    logic [31:0]      cdb1_val;

    logic             alu_instr_valid;
    logic [OPC_W-1:0] alu_opcode;
    logic [31:0]      alu_vj;
    logic [31:0]      alu_vk;
    logic [31:0]      alu_A;
    logic [ROB_W-1:0] alu_rob_pos;

    // Issue stage / CDB producers / ALU consumer side
    modport master (
        output issue_valid, issue_opcode, issue_vj, issue_vk, issue_A,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob_pos,
               cdb0_valid, cdb0_rob_pos, cdb0_val,
               cdb1_valid, cdb1_rob_pos, cdb1_val,
        input  rs_full,
               alu_instr_valid, alu_opcode, alu_vj, alu_vk, alu_A, alu_rob_pos
    );

    // Reservation station side
    modport slave (
        input  issue_valid, issue_opcode, issue_vj, issue_vk, issue_A,
               issue_qj_busy, issue_qk_busy, issue_qj, issue_qk, issue_rob_pos,
               cdb0_valid, cdb0_rob_pos, cdb0_val,
               cdb1_valid, cdb1_rob_pos, cdb1_val,
        output rs_full,
               alu_instr_valid, alu_opcode, alu_vj, alu_vk, alu_A, alu_rob_pos
    );

endinterface

// File: rtl/rs_alu_scheduler_select.sv
// rs_select: dispatch pick among ready slots and lowest free slot for allocation.
// Optional build macro: RS_OLDEST_FIRST_EN (age matrix input, oldest-ready pick).
module rs_select
    import rs_alu_scheduler_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF,
    localparam int IDX_W  = $clog2(RS_SIZE)
)(
    input  logic [RS_SIZE-1:0]              valid,
    input  logic [RS_SIZE-1:0]              ready,
`ifdef RS_OLDEST_FIRST_EN
    // age[i][j] = 1 means slot i was allocated after slot j
    input  logic [RS_SIZE-1:0][RS_SIZE-1:0] age,
`endif
    output logic                            disp_valid,
    output logic [RS_SIZE-1:0]              disp_onehot,
    output logic [IDX_W-1:0]                disp_idx,
    output logic                            free_valid,
    output logic [IDX_W-1:0]                free_idx
);

    logic [RS_SIZE-1:0] cand;
    logic [RS_SIZE-1:0] free_vec;

    // Candidate filter: every ready slot, or only the ready slot with no older ready slot
    always_comb begin
        cand = ready;
`ifdef RS_OLDEST_FIRST_EN
        for (int i = 0; i < RS_SIZE; i++) begin
            cand[i] = ready[i] && ((age[i] & ready) == '0);
        end
`endif
    end

    // Lowest-index candidate becomes the dispatch one-hot and index
    always_comb begin
        disp_valid  = |cand;
        disp_onehot = cand & (~cand + RS_SIZE'(1));
        disp_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i]) begin
                disp_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index invalid slot receives the next allocation
    always_comb begin
        free_vec   = ~valid;
        free_valid = |free_vec;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rs_alu_scheduler.sv
// ALU reservation station: holds issued instructions until both operands are
// captured from the CDBs, then dispatches one ready entry per cycle to the ALU.
// Optional build macro: RS_OLDEST_FIRST_EN (oldest-ready dispatch via age matrix;
// lowest-index dispatch when undefined).
module rs_alu_scheduler
    import rs_alu_scheduler_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEF
)(
    input  logic clk,
    input  logic rst_n,
    input  logic rdy,
    input  logic clear,
    rs_alu_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t          ent   [RS_SIZE];
    rs_entry_t          ent_n [RS_SIZE];
    rs_entry_t          new_ent;
    alu_req_t           alu_q;
    alu_req_t           alu_n;
    opnd_t              oj;
    opnd_t              ok;
    opnd_t              new_j;
    opnd_t              new_k;

    logic [RS_SIZE-1:0] valid_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic               rs_full;
    logic               alloc_en;
    logic               disp_valid;
    logic [RS_SIZE-1:0] disp_onehot;
    logic [IDX_W-1:0]   disp_idx;
    logic               free_valid;
    logic [IDX_W-1:0]   free_idx;

`ifdef RS_OLDEST_FIRST_EN
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_n;
`endif

    // Per-slot valid and ready vectors, taken from registered state only
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            valid_vec[i] = ent[i].valid;
            ready_vec[i] = ent[i].valid && !ent[i].qj_busy && !ent[i].qk_busy;
        end
    end

    assign rs_full  = &valid_vec;
    assign alloc_en = bus.issue_valid && !rs_full && free_valid && !clear;

    rs_select #(
        .RS_SIZE     (RS_SIZE)
    ) u_select (
        .valid       (valid_vec),
        .ready       (ready_vec),
`ifdef RS_OLDEST_FIRST_EN
        .age         (age_q),
`endif
        .disp_valid  (disp_valid),
        .disp_onehot (disp_onehot),
        .disp_idx    (disp_idx),
        .free_valid  (free_valid),
        .free_idx    (free_idx)
    );

    // Incoming instruction with same-cycle CDB bypass on both operands
    always_comb begin
        new_j = snoop(bus.issue_qj_busy, bus.issue_vj, bus.issue_qj,
                      bus.cdb0_valid, bus.cdb0_rob_pos, bus.cdb0_val,
                      bus.cdb1_valid, bus.cdb1_rob_pos, bus.cdb1_val);
        new_k = snoop(bus.issue_qk_busy, bus.issue_vk, bus.issue_qk,
                      bus.cdb0_valid, bus.cdb0_rob_pos, bus.cdb0_val,
                      bus.cdb1_valid, bus.cdb1_rob_pos, bus.cdb1_val);
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.opcode  = bus.issue_opcode;
        new_ent.vj      = new_j.val;
        new_ent.qj_busy = new_j.busy;
        new_ent.qj      = bus.issue_qj;
        new_ent.vk      = new_k.val;
        new_ent.qk_busy = new_k.busy;
        new_ent.qk      = bus.issue_qk;
        new_ent.a       = bus.issue_A;
        new_ent.rob_pos = bus.issue_rob_pos;
    end

    // Next slot state (wakeup, dispatch, allocation, flush) and next ALU request
    always_comb begin
        oj    = '0;
        ok    = '0;
        alu_n = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_n[i] = ent[i];
            if (ent[i].valid) begin
                oj = snoop(ent[i].qj_busy, ent[i].vj, ent[i].qj,
                           bus.cdb0_valid, bus.cdb0_rob_pos, bus.cdb0_val,
                           bus.cdb1_valid, bus.cdb1_rob_pos, bus.cdb1_val);
                ok = snoop(ent[i].qk_busy, ent[i].vk, ent[i].qk,
                           bus.cdb0_valid, bus.cdb0_rob_pos, bus.cdb0_val,
                           bus.cdb1_valid, bus.cdb1_rob_pos, bus.cdb1_val);
                ent_n[i].qj_busy = oj.busy;
                ent_n[i].vj      = oj.val;
                ent_n[i].qk_busy = ok.busy;
                ent_n[i].vk      = ok.val;
            end
            // The dispatched slot leaves at the same edge its fields go to the ALU
            if (disp_onehot[i]) begin
                ent_n[i].valid = 1'b0;
            end
        end

        if (disp_valid) begin
            alu_n.instr_valid = 1'b1;
            alu_n.opcode      = ent[disp_idx].opcode;
            alu_n.vj          = ent[disp_idx].vj;
            alu_n.vk          = ent[disp_idx].vk;
            alu_n.a           = ent[disp_idx].a;
            alu_n.rob_pos     = ent[disp_idx].rob_pos;
        end

        // The free slot is never the dispatched one, so both can happen together
        if (alloc_en) begin
            ent_n[free_idx] = new_ent;
        end

        if (clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_n[i].valid = 1'b0;
            end
            alu_n = '0;
        end
    end

    // Slot and ALU request registers; rdy low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
            alu_q <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= ent_n[i];
            end
            alu_q <= alu_n;
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // Age matrix update: new slot is younger than every live slot; leavers drop out
    always_comb begin
        age_n = age_q;
        if (clear) begin
            age_n = '0;
        end else begin
            if (alloc_en) begin
                age_n[free_idx] = valid_vec;
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (disp_onehot[i]) begin
                    age_n[i] = '0;
                end
                age_n[i] = age_n[i] & ~disp_onehot;
            end
        end
    end

    // Age matrix register, frozen together with the slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else if (rdy) begin
            age_q <= age_n;
        end
    end
`endif

    assign bus.rs_full         = rs_full;
    assign bus.alu_instr_valid = alu_q.instr_valid;
    assign bus.alu_opcode      = alu_q.opcode;
    assign bus.alu_vj          = alu_q.vj;
    assign bus.alu_vk          = alu_q.vk;
    assign bus.alu_A           = alu_q.a;
    assign bus.alu_rob_pos     = alu_q.rob_pos;

endmodule
